instruction_fetcher: RTL and testbench
======================================

// Module: instruction_fetcher
// PURPOSE
// - Front-end instruction source for the decode/dispatch stage. Owns the PC, fetches 32-bit words from the
//   memory controller, presents one instruction at a time on inst_valid/inst_addr/inst_data, and advances
//   to f_next_pc when the decoder asserts f_ok.
// - Redirects to rob_new_pc on a ROB flush (mispredict). Optional direct-mapped instruction cache.
// PARAMETERS
// - RESET_PC        32'h0  PC loaded on reset
// - ICACHE_IDX_BIT  4      log2(cache lines), one word per line; used only with ICACHE_EN
// PORTS
// - clk_in        in   1   system clock
// - rst_n_in      in   1   reset, asynchronous, active-low
// - rdy_in        in   1   global ready; low freezes all state
// - rob_clear     in   1   flush: discard current/in-flight fetch, redirect
// - rob_new_pc    in   32  redirect target, valid with rob_clear
// - inst_valid    out  1   instruction word presented to decoder
// - inst_addr     out  32  PC of presented instruction
// - inst_data     out  32  instruction word
// - f_next_pc     in   32  next PC chosen by decoder (pc+4 / JAL / JALR target)
// - f_ok          in   1   decoder accepts presented instruction this cycle
// - mem_req       out  1   fetch request to memory controller
// - mem_addr      out  32  word address of request (low 2 bits 0)
// - mem_done      in   1   one-cycle pulse: mem_data valid
// - mem_data      in   32  returned instruction word
// BEHAVIOUR
// - Reset (async, rst_n_in low): state=REQ, pc=RESET_PC, inst_valid=0, inst_addr=0, inst_data=0, mem_req=0,
//   mem_addr=0; cache valid bits all 0. All updates otherwise on posedge clk_in, and only when rdy_in=1.
// - States: REQ, WAIT, HOLD, DISCARD.
//   REQ:     mem_req<=1, mem_addr<=pc; -> WAIT.
//   WAIT:    mem_req held 1 until mem_done. On mem_done: inst_data<=mem_data, inst_addr<=pc, inst_valid<=1,
//            mem_req<=0; -> HOLD.
//   HOLD:    inst_valid/addr/data stable until f_ok. On f_ok: pc<=f_next_pc, inst_valid<=0; -> REQ.
//            inst_valid deasserts the cycle after f_ok, so the decoder never sees a stale word twice.
//   DISCARD: entered on rob_clear while in WAIT and mem_done not this cycle; mem_req<=0; wait for mem_done,
//            drop the word; -> REQ.
// - Latency (no cache): f_ok edge -> REQ (1) -> WAIT; inst_valid rises cycle after mem_done.
// - rob_clear (any state): pc<=rob_new_pc, inst_valid<=0, mem_req<=0. Next state REQ, except from WAIT
//   without mem_done -> DISCARD. rob_clear beats f_ok and mem_done in same cycle (word dropped, f_ok ignored).
// - rob_clear during DISCARD: update pc only; remain DISCARD.
// - PC arithmetic 32-bit, wraps modulo 2^32; f_next_pc/rob_new_pc taken as-is (low bits not checked).
// - rdy_in low: no state, PC, output or cache change; mem_done arriving while rdy_in low is lost, so the
//   memory controller must also honour rdy_in.
// CONFIGURATION
// - ICACHE_EN defined: 2^ICACHE_IDX_BIT-line direct-mapped cache, index=pc[ICACHE_IDX_BIT+1:2],
//   tag=pc[31:ICACHE_IDX_BIT+2]. In REQ, on hit: inst_data<=line, inst_addr<=pc, inst_valid<=1, no mem_req;
//   -> HOLD (1-cycle fetch). Miss: as REQ above. Fill on every accepted mem_done (not in DISCARD).
//   rob_clear does not invalidate the cache; only reset does.
// - ICACHE_EN undefined: no cache storage; every fetch goes to memory.
// TESTING
// - Reset with RESET_PC=0, mem returns 32'h00000013 after 3 cycles -> mem_addr=0, inst_valid=1 addr=0,
//   data=32'h13; held over 5 cycles of f_ok=0.
// - f_ok=1 with f_next_pc=32'h4 -> inst_valid=0 next cycle, next mem_addr=32'h4.
// - JAL target: f_next_pc=32'h100 on f_ok -> next mem_addr=32'h100, inst_addr=32'h100.
// - rob_clear, rob_new_pc=32'h80, during WAIT -> DISCARD; returned word dropped (inst_valid stays 0);
//   new mem_addr=32'h80.
// - rob_clear and f_ok same cycle in HOLD (f_next_pc=32'h8, rob_new_pc=32'h40) -> next fetch at 32'h40.
// - ICACHE_EN: loop 0x0->0x4->0x0 -> second fetch of 0x0 has no mem_req, inst_valid 1 cycle after REQ entry.

Source files
------------

// File: rtl/instruction_fetcher_if.sv
// rtl/instruction_fetcher_if.sv - decoder and memory-controller bundle for instruction_fetcher
//
// Purpose: groups the decode-side presentation handshake and the memory-side
// fetch request/response signals seen by the instruction fetcher.
// Signals:
//   inst_valid/inst_addr/inst_data  fetcher -> decoder, presented instruction
//   f_next_pc/f_ok                  decoder -> fetcher, accept and next PC
//   mem_req/mem_addr                fetcher -> memory, word fetch request
//   mem_done/mem_data               memory  -> fetcher, one-cycle response
// Modports: master = fetcher side, slave = decoder/memory side.

interface instruction_fetcher_if;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] f_next_pc;
  logic        f_ok;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  modport master (
    output inst_valid, inst_addr, inst_data, mem_req, mem_addr,
    input  f_next_pc, f_ok, mem_done, mem_data
  );

  modport slave (
    input  inst_valid, inst_addr, inst_data, mem_req, mem_addr,
    output f_next_pc, f_ok, mem_done, mem_data
  );
endinterface

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - PC owner and instruction fetch front-end with optional I-cache
//
// Purpose: fetches 32-bit instruction words from the memory controller, presents
// one at a time to the decoder, advances to the decoder's next PC on f_ok and
// redirects on a ROB flush. Optional direct-mapped cache enabled by the
// ICACHE_EN macro (one word per line, 2^ICACHE_IDX_BIT lines).
// Ports:
//   clk_in      system clock
//   rst_n_in    asynchronous active-low reset
//   rdy_in      global ready; low freezes every register
//   rob_clear   flush: drop current/in-flight fetch and redirect
//   rob_new_pc  redirect target, valid with rob_clear
//   bus         instruction_fetcher_if.master (decoder + memory signals)

module instruction_fetcher #(
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter int          ICACHE_IDX_BIT = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          rob_clear,
  input  logic [31:0]                   rob_new_pc,
  instruction_fetcher_if.master         bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

`ifdef ICACHE_EN
  localparam int CACHE_LINES = 1 << ICACHE_IDX_BIT;
  localparam int TAG_W       = 30 - ICACHE_IDX_BIT;

  logic [31:0]               cache_data_q [CACHE_LINES];
  logic [TAG_W-1:0]          cache_tag_q  [CACHE_LINES];
  logic [CACHE_LINES-1:0]    cache_vld_q;
  logic [ICACHE_IDX_BIT-1:0] cache_idx;
  logic [TAG_W-1:0]          cache_tag;
  logic                      cache_hit;
  logic                      cache_fill;

  // pc_q only moves in HOLD or on a flush, so during WAIT it still names the
  // word being returned and can index the fill.
  assign cache_idx  = pc_q[ICACHE_IDX_BIT+1:2];
  assign cache_tag  = pc_q[31:ICACHE_IDX_BIT+2];
  assign cache_hit  = cache_vld_q[cache_idx] && (cache_tag_q[cache_idx] == cache_tag);
  // A word dropped by a same-cycle flush is not written into the cache.
  assign cache_fill = (state_q == S_WAIT) && bus.mem_done && !rob_clear;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cache_vld_q <= '0;
    end else if (rdy_in && cache_fill) begin
      cache_vld_q[cache_idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in && cache_fill) begin
      cache_data_q[cache_idx] <= bus.mem_data;
      cache_tag_q[cache_idx]  <= cache_tag;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_addr_d  = inst_addr_q;
    inst_data_d  = inst_data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;

    case (state_q)
      S_REQ: begin
`ifdef ICACHE_EN
        if (cache_hit) begin
          inst_data_d  = cache_data_q[cache_idx];
          inst_addr_d  = pc_q;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end else begin
`else
        begin
`endif
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_q[31:2], 2'b00};
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_done) begin
          inst_data_d  = bus.mem_data;
          inst_addr_d  = pc_q;
          inst_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.f_ok) begin
          pc_d         = bus.f_next_pc;
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_DISCARD: begin
        mem_req_d = 1'b0;
        if (bus.mem_done) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // Flush overrides whatever the state logic chose this cycle, including a
    // same-cycle f_ok or mem_done.
    if (rob_clear) begin
      pc_d         = rob_new_pc;
      inst_valid_d = 1'b0;
      inst_addr_d  = inst_addr_q;
      inst_data_d  = inst_data_q;
      mem_req_d    = 1'b0;
      mem_addr_d   = mem_addr_q;
      if (state_q == S_WAIT) begin
        // A request is still in flight: drain its response before refetching.
        state_d = bus.mem_done ? S_REQ : S_DISCARD;
      end else if (state_q == S_DISCARD) begin
        // Keep draining; once the in-flight word has arrived there is nothing
        // left to wait for, so the state logic's choice stands.
        state_d = bus.mem_done ? S_REQ : S_DISCARD;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_addr_q  <= 32'h0;
      inst_data_q  <= 32'h0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_addr_q  <= inst_addr_d;
      inst_data_q  <= inst_data_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_addr  = inst_addr_q;
  assign bus.inst_data  = inst_data_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - directed and randomized bench for instruction_fetcher

module tb_instruction_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        rob_clear;
  logic [31:0] rob_new_pc;

  instruction_fetcher_if bus();

  instruction_fetcher #(
    .RESET_PC      (32'h0),
    .ICACHE_IDX_BIT(4)
  ) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rdy_in    (rdy_in),
    .rob_clear (rob_clear),
    .rob_new_pc(rob_new_pc),
    .bus       (bus)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // memory contents: a fixed function of the word address (0 -> 32'h13)
  function automatic logic [31:0] memfunc(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // reference state
  logic [31:0] exp_pc;
  bit          busy, stale;
  int          cnt, mem_lat;
  logic [31:0] req_addr;
  logic        p_valid, p_req;
  logic [31:0] p_addr, p_data, p_maddr;
  int          n_inst, since;

  task automatic sample_prev();
    p_valid = bus.inst_valid;
    p_req   = bus.mem_req;
    p_addr  = bus.inst_addr;
    p_data  = bus.inst_data;
    p_maddr = bus.mem_addr;
  endtask

  // Called at a negedge: drives memory, crosses one posedge, samples and checks.
  task automatic tick();
    logic done_now, drop, acc_clear, acc_ok, r;
    done_now = 1'b0;
    if (busy && rdy_in) begin
      cnt--;
      if (cnt <= 0) done_now = 1'b1;
    end
    if (done_now && stale) rob_clear = 1'b0;
    bus.mem_done = done_now;
    bus.mem_data = done_now ? memfunc(req_addr) : $urandom;
    @(posedge clk_in);
    r         = rdy_in;
    acc_clear = r && rob_clear;
    acc_ok    = r && bus.f_ok && p_valid && !rob_clear;
    drop      = done_now && (stale || rob_clear);
    if (acc_clear) exp_pc = rob_new_pc;
    else if (acc_ok) exp_pc = bus.f_next_pc;
    if (done_now) begin
      busy  = 0;
      stale = 0;
    end else if (acc_clear && busy) begin
      stale = 1;
    end
    @(negedge clk_in);
    bus.mem_done = 1'b0;
    since++;
    if (!r) begin
      check_eq("freeze_ctl", {30'b0, bus.inst_valid, bus.mem_req}, {30'b0, p_valid, p_req});
      check_eq("freeze_addr", bus.inst_addr, p_addr);
      check_eq("freeze_data", bus.inst_data, p_data);
      check_eq("freeze_maddr", bus.mem_addr, p_maddr);
    end else begin
      if (bus.mem_req && !p_req) begin
        check_eq("req_addr", bus.mem_addr, exp_pc);
        check_eq("req_when_idle", {31'b0, busy}, 32'h0);
      end
      if (bus.inst_valid && !p_valid) begin
        check_eq("inst_addr", bus.inst_addr, exp_pc);
        check_eq("inst_data", bus.inst_data, memfunc(exp_pc));
`ifndef ICACHE_EN
        check_eq("valid_after_done", {31'b0, done_now}, 32'h1);
`endif
        n_inst++;
        since = 0;
      end
      if (bus.inst_valid && p_valid) begin
        check_eq("hold_addr", bus.inst_addr, p_addr);
        check_eq("hold_data", bus.inst_data, p_data);
      end
      if (acc_clear || acc_ok) check_eq("valid_drop", {31'b0, bus.inst_valid}, 32'h0);
      if (done_now) check_eq("done_to_valid", {31'b0, bus.inst_valid}, {31'b0, !drop});
    end
    if (bus.mem_req && !busy) begin
      busy     = 1;
      cnt      = mem_lat;
      req_addr = bus.mem_addr;
    end
    sample_prev();
  endtask

  task automatic wait_for(input bit want_req, input string tag, output int n);
    n = 0;
    while (((want_req ? bus.mem_req : bus.inst_valid) !== 1'b1) && n < 60) begin
      tick();
      n++;
    end
    if ((want_req ? bus.mem_req : bus.inst_valid) !== 1'b1)
      check_eq({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic accept(input logic [31:0] nxt);
    bus.f_ok      = 1'b1;
    bus.f_next_pc = nxt;
    tick();
    bus.f_ok      = 1'b0;
  endtask

  function automatic logic [31:0] pick_pc(input logic [31:0] base);
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return base + 32'h4;
      6, 7:             return 32'($urandom_range(0, 31)) << 2;
      8:                return 32'hFFFF_FFFC;
      default:          return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    int  n;
    bit  seen;
    rst_n_in      = 1'b0;
    rdy_in        = 1'b1;
    rob_clear     = 1'b0;
    rob_new_pc    = 32'h0;
    bus.f_ok      = 1'b0;
    bus.f_next_pc = 32'h0;
    bus.mem_done  = 1'b0;
    bus.mem_data  = 32'h0;
    exp_pc = 32'h0; busy = 0; stale = 0; cnt = 0; mem_lat = 3;
    req_addr = 32'h0; n_inst = 0; since = 0;
    repeat (3) @(negedge clk_in);
    check_eq("rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    check_eq("rst_addr", bus.inst_addr, 32'h0);
    check_eq("rst_data", bus.inst_data, 32'h0);
    check_eq("rst_req", {31'b0, bus.mem_req}, 32'h0);
    check_eq("rst_maddr", bus.mem_addr, 32'h0);
    sample_prev();
    rst_n_in = 1'b1;

    // first fetch from reset PC, memory latency 3
    tick();
    check_eq("t1_req", {31'b0, bus.mem_req}, 32'h1);
    check_eq("t1_maddr", bus.mem_addr, 32'h0);
    wait_for(1'b0, "t1_valid", n);
    check_eq("t1_latency", n, 3);
    check_eq("t1_addr", bus.inst_addr, 32'h0);
    check_eq("t1_data", bus.inst_data, 32'h13);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t1_hold_valid", {31'b0, bus.inst_valid}, 32'h1);
      check_eq("t1_hold_data", bus.inst_data, 32'h13);
    end

    // sequential advance
    accept(32'h4);
    check_eq("t2_valid_off", {31'b0, bus.inst_valid}, 32'h0);
    tick();
    check_eq("t2_req", {31'b0, bus.mem_req}, 32'h1);
    check_eq("t2_maddr", bus.mem_addr, 32'h4);
    wait_for(1'b0, "t2_valid", n);
    check_eq("t2_addr", bus.inst_addr, 32'h4);

    // jump target
    accept(32'h100);
    wait_for(1'b1, "t3_req", n);
    check_eq("t3_maddr", bus.mem_addr, 32'h100);
    wait_for(1'b0, "t3_valid", n);
    check_eq("t3_addr", bus.inst_addr, 32'h100);
    check_eq("t3_data", bus.inst_data, memfunc(32'h100));

    // flush while waiting on memory: in-flight word must be dropped
    accept(32'h200);
    wait_for(1'b1, "t4_req", n);
    rob_clear  = 1'b1;
    rob_new_pc = 32'h80;
    tick();
    rob_clear  = 1'b0;
    seen = 0;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 60) begin
      tick();
      n++;
      if (bus.inst_valid === 1'b1) seen = 1;
    end
    check_eq("t4_no_stale", {31'b0, seen}, 32'h0);
    check_eq("t4_maddr", bus.mem_addr, 32'h80);
    wait_for(1'b0, "t4_valid", n);
    check_eq("t4_addr", bus.inst_addr, 32'h80);

    // flush and accept together: flush wins
    rob_clear     = 1'b1;
    rob_new_pc    = 32'h40;
    accept(32'h8);
    rob_clear     = 1'b0;
    wait_for(1'b1, "t5_req", n);
    check_eq("t5_maddr", bus.mem_addr, 32'h40);
    wait_for(1'b0, "t5_valid", n);
    check_eq("t5_addr", bus.inst_addr, 32'h40);

`ifdef ICACHE_EN
    // loop 0 -> 4 -> 0: second visit to 0 is a hit
    accept(32'h0);
    wait_for(1'b0, "t6_v0", n);
    accept(32'h4);
    wait_for(1'b0, "t6_v4", n);
    accept(32'h0);
    check_eq("t6_req_off", {31'b0, bus.mem_req}, 32'h0);
    tick();
    check_eq("t6_hit_valid", {31'b0, bus.inst_valid}, 32'h1);
    check_eq("t6_hit_req", {31'b0, bus.mem_req}, 32'h0);
    check_eq("t6_hit_addr", bus.inst_addr, 32'h0);
    check_eq("t6_hit_data", bus.inst_data, 32'h13);
`endif

    // randomized traffic against the scoreboard in tick()
    n_inst = 0;
    since  = 0;
    for (int i = 0; i < 3000; i++) begin
      rdy_in        = ($urandom_range(0, 9) != 0);
      mem_lat       = $urandom_range(1, 5);
      bus.f_ok      = p_valid && ($urandom_range(0, 1) == 1);
      bus.f_next_pc = pick_pc(p_addr);
      rob_clear     = ($urandom_range(0, 29) == 0);
      rob_new_pc    = pick_pc(exp_pc);
      tick();
      if (since > 300) begin
        check_eq("progress_stall", since, 0);
        break;
      end
    end
    check_eq("progress_count", {31'b0, (n_inst > 50)}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
